// File: rtl/pwm_peripheral.sv
// Register decode and 16-pin PWM output stage driven by the SPI peripheral's
// two transaction bytes; each pin is off, statically on, or PWM-modulated.
module pwm_peripheral #(
    parameter int unsigned CLK_DIV  = 13,
    parameter int unsigned MAX_ADDR = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] cfg_lo,
    input  logic [7:0] cfg_hi,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic       pwm_tick
);

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned ADDR_W = 7;
    localparam int unsigned PIN_W  = 16;
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned PRE_W  = 8;

    localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(CLK_DIV - 1);
    localparam logic [ADDR_W-1:0] MAX_A    = ADDR_W'(MAX_ADDR);
    localparam logic [CNT_W-1:0]  CNT_LAST = '1;

    localparam logic [ADDR_W-1:0] A_EN_OUT_LO = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] A_EN_OUT_HI = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] A_EN_PWM_LO = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] A_EN_PWM_HI = ADDR_W'(3);
    localparam logic [ADDR_W-1:0] A_DUTY      = ADDR_W'(4);

    // SPI transaction as seen on the two bytes
    typedef struct packed {
        logic [BYTE_W-1:0] data;
        logic [ADDR_W-1:0] addr;
        logic              wr_flag;
    } cfg_t;

    cfg_t              cfg_c;
    cfg_t              prev_cfg;
    logic              wr_c;

    logic [BYTE_W-1:0] en_out_lo;
    logic [BYTE_W-1:0] en_out_hi;
    logic [BYTE_W-1:0] en_pwm_lo;
    logic [BYTE_W-1:0] en_pwm_hi;
    logic [BYTE_W-1:0] duty;
    logic [BYTE_W-1:0] duty_act;

    logic [PRE_W-1:0]  pre_cnt;
    logic [CNT_W-1:0]  pwm_cnt;
    logic              step_c;
    logic              wrap_c;
    logic              level_c;
    logic [PIN_W-1:0]  pin_c;

    assign cfg_c = {cfg_hi, cfg_lo};

    // A write is any change of the byte pair that carries a valid write request
    assign wr_c = (cfg_c != prev_cfg) && cfg_c.wr_flag && (cfg_c.addr <= MAX_A);

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_cfg <= '0;
        end else begin
            prev_cfg <= cfg_c;
        end
    end

    // Control register file
    always_ff @(posedge clk) begin
        if (rst) begin
            en_out_lo <= '0;
            en_out_hi <= '0;
            en_pwm_lo <= '0;
            en_pwm_hi <= '0;
            duty      <= '0;
        end else if (wr_c) begin
            case (cfg_c.addr)
                A_EN_OUT_LO: en_out_lo <= cfg_c.data;
                A_EN_OUT_HI: en_out_hi <= cfg_c.data;
                A_EN_PWM_LO: en_pwm_lo <= cfg_c.data;
                A_EN_PWM_HI: en_pwm_hi <= cfg_c.data;
                A_DUTY:      duty      <= cfg_c.data;
                default: ;
            endcase
        end
    end

    assign step_c = (pre_cnt == PRE_LAST);
    assign wrap_c = step_c && (pwm_cnt == CNT_LAST);

    // Prescaler and PWM period counter
    always_ff @(posedge clk) begin
        if (rst) begin
            pre_cnt <= '0;
            pwm_cnt <= '0;
        end else begin
            if (step_c) begin
                pre_cnt <= '0;
                pwm_cnt <= pwm_cnt + CNT_W'(1);
            end else begin
                pre_cnt <= pre_cnt + PRE_W'(1);
            end
        end
    end

    // Duty shadow only reloads at the period boundary so a period is never torn
    always_ff @(posedge clk) begin
        if (rst) begin
            duty_act <= '0;
            pwm_tick <= 1'b0;
        end else begin
            pwm_tick <= wrap_c;
            if (wrap_c) begin
                duty_act <= duty;
            end
        end
    end

    always_comb begin
        level_c = 1'b0;
        if (duty_act == '0) begin
            level_c = 1'b0;
        end else if (duty_act == '1) begin
            level_c = 1'b1;
        end else begin
            level_c = (pwm_cnt < duty_act);
        end
    end

    assign pin_c = {en_out_hi, en_out_lo}
                 & (~{en_pwm_hi, en_pwm_lo} | {PIN_W{level_c}});

    always_ff @(posedge clk) begin
        if (rst) begin
            uo_out  <= '0;
            uio_out <= '0;
        end else begin
            uo_out  <= pin_c[BYTE_W-1:0];
            uio_out <= pin_c[PIN_W-1:BYTE_W];
        end
    end

endmodule

// File: tb/tb_pwm_peripheral.sv
// Self-checking bench for pwm_peripheral: register decode vectors, write latency,
// PWM waveform shape per period, and tick spacing with a mid-period reset.
module tb_pwm_peripheral;

    logic       clk = 1'b0;
    logic       rst;
    logic       rst3;
    logic [7:0] cfg_lo;
    logic [7:0] cfg_hi;
    logic [7:0] uo1, uio1, uo3, uio3;
    logic       tick1, tick3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pwm_peripheral #(.CLK_DIV(1), .MAX_ADDR(4)) dut1 (
        .clk(clk), .rst(rst), .cfg_lo(cfg_lo), .cfg_hi(cfg_hi),
        .uo_out(uo1), .uio_out(uio1), .pwm_tick(tick1)
    );

    pwm_peripheral #(.CLK_DIV(3), .MAX_ADDR(4)) dut3 (
        .clk(clk), .rst(rst3), .cfg_lo(cfg_lo), .cfg_hi(cfg_hi),
        .uo_out(uo3), .uio_out(uio3), .pwm_tick(tick3)
    );

    typedef struct {
        logic [7:0] lo;
        logic [7:0] hi;
        logic [7:0] exp_uo;
        logic [7:0] exp_uio;
    } vec_t;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [7:0] lo, input logic [7:0] hi);
        cfg_lo = lo;
        cfg_hi = hi;
    endtask

    task automatic wait_tick(input bit use3, input int limit, output int n, output bit ok);
        ok = 1'b0;
        n  = 0;
        while (n < limit && !ok) begin
            @(negedge clk);
            n++;
            ok = use3 ? tick3 : tick1;
        end
    endtask

    function automatic bit exp_level(input logic [7:0] d, input int k);
        if (d == 8'h00) return 1'b0;
        if (d == 8'hFF) return 1'b1;
        return k < int'(d);
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs [9];
        logic [15:0] exp_q [$];
        logic [15:0] e;
        logic [7:0]  duties [4];
        int          exp_highs [4];
        int          n, highs, bad, side;
        bit          ok;

        vecs[0] = '{8'h01, 8'hA5, 8'hA5, 8'h00};
        vecs[1] = '{8'h03, 8'h3C, 8'hA5, 8'h3C};
        vecs[2] = '{8'h0B, 8'hFF, 8'hA5, 8'h3C};
        vecs[3] = '{8'h02, 8'hFF, 8'hA5, 8'h3C};
        vecs[4] = '{8'h01, 8'h0F, 8'h0F, 8'h3C};
        vecs[5] = '{8'h05, 8'h03, 8'h0C, 8'h3C};
        vecs[6] = '{8'h07, 8'h0C, 8'h0C, 8'h30};
        vecs[7] = '{8'h05, 8'h00, 8'h0F, 8'h30};
        vecs[8] = '{8'h07, 8'h00, 8'h0F, 8'h3C};
        duties    = '{8'h40, 8'hFF, 8'h00, 8'hFE};
        exp_highs = '{64, 256, 0, 254};

        // reset state
        rst  = 1'b1;
        rst3 = 1'b1;
        drive(8'h00, 8'h00);
        @(negedge clk);
        check("rst uo", 16'(uo1), 16'h00);
        check("rst uio", 16'(uio1), 16'h00);
        check("rst tick", 16'(tick1), 16'h0);
        rst  = 1'b0;
        rst3 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("idle uo", 16'(uo1), 16'h00);

        // table-driven register decode
        for (int i = 0; i < 9; i++) begin
            drive(vecs[i].lo, vecs[i].hi);
            exp_q.push_back({vecs[i].exp_uo, vecs[i].exp_uio});
            @(negedge clk);
            @(negedge clk);
            e = exp_q.pop_front();
            check($sformatf("vec%0d uo", i), 16'(uo1), 16'(e[15:8]));
            check($sformatf("vec%0d uio", i), 16'(uio1), 16'(e[7:0]));
        end

        // back-to-back writes and one-cycle pin latency
        drive(8'h01, 8'h11);
        @(negedge clk);
        check("lat uo old", 16'(uo1), 16'h0F);
        drive(8'h03, 8'h22);
        @(negedge clk);
        check("b2b uo", 16'(uo1), 16'h11);
        check("b2b uio old", 16'(uio1), 16'h3C);
        @(negedge clk);
        check("b2b uio", 16'(uio1), 16'h22);

        // valid pattern present across reset release is applied
        rst = 1'b1;
        drive(8'h01, 8'h5A);
        @(negedge clk);
        check("rst2 uo", 16'(uo1), 16'h00);
        check("rst2 uio", 16'(uio1), 16'h00);
        rst = 1'b0;
        @(negedge clk);
        check("rel uo lat", 16'(uo1), 16'h00);
        @(negedge clk);
        check("rel uo", 16'(uo1), 16'h5A);
        check("rel uio", 16'(uio1), 16'h00);

        // PWM setup on pin 0, pins 1..7 static
        drive(8'h01, 8'hFF);
        @(negedge clk);
        drive(8'h05, 8'h01);
        @(negedge clk);
        @(negedge clk);
        check("static en", 16'(uo1), 16'hFE);
        wait_tick(1'b0, 600, n, ok);
        check("tick1 first", 16'(ok), 16'h1);
        repeat (5) @(negedge clk);
        drive(8'h09, duties[0]);
        wait_tick(1'b0, 600, n, ok);
        check("tick1 load", 16'(ok), 16'h1);

        // four consecutive periods; next duty written mid-period each time
        for (int p = 0; p < 4; p++) begin
            highs = 0;
            bad   = 0;
            side  = 0;
            for (int k = 0; k < 256; k++) begin
                @(negedge clk);
                if (uo1[0] !== exp_level(duties[p], k)) bad++;
                if (uo1[7:1] !== 7'h7F) side++;
                if (uo1[0] === 1'b1) highs++;
                if (k == 100 && p < 3) drive(8'h09, duties[p+1]);
            end
            check($sformatf("p%0d highs", p), 16'(highs), 16'(exp_highs[p]));
            check($sformatf("p%0d shape", p), 16'(bad), 16'h0);
            check($sformatf("p%0d static pins", p), 16'(side), 16'h0);
            check($sformatf("p%0d tick", p), 16'(tick1), 16'h1);
        end

        // CLK_DIV=3 tick spacing and mid-period reset
        wait_tick(1'b1, 2000, n, ok);
        check("tick3 first", 16'(ok), 16'h1);
        wait_tick(1'b1, 1000, n, ok);
        check("tick3 spacing", 16'(n), 16'd768);
        repeat (300) @(negedge clk);
        rst3 = 1'b1;
        @(negedge clk);
        check("rst3 tick", 16'(tick3), 16'h0);
        check("rst3 uo", 16'(uo3), 16'h00);
        check("rst3 uio", 16'(uio3), 16'h00);
        rst3 = 1'b0;
        wait_tick(1'b1, 1000, n, ok);
        check("tick3 after rst", 16'(n), 16'd768);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
